dec_scan: RTL and testbench
===========================

DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning select width; output width is 2**N.
REQ-002 The block SHALL have parameter DW, default 4, meaning dwell-counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1, block enable; low forces idle.
REQ-006 The block SHALL have port load, input, 1, one-cycle command strobe sampling mode, sel and dwell.
REQ-007 The block SHALL have port mode, input, 1, command type: 0 = direct decode, 1 = scan.
REQ-008 The block SHALL have port sel, input, N, decode address or scan start index.
REQ-009 The block SHALL have port dwell, input, DW, scan hold length; each output stays active dwell+1 cycles.
REQ-010 The block SHALL have port y, output, 2**N, registered one-hot decode output.
REQ-011 The block SHALL have port vld, output, 1, high when y carries a valid one-hot value.
REQ-012 The block SHALL have port wrap, output, 1, one-cycle pulse when scan advances from index 2**N-1 to 0.

Function
REQ-013 State machine SHALL have exactly three states: IDLE, HOLD, SCAN.
REQ-014 y SHALL be all-zero in IDLE and exactly one-hot in HOLD and SCAN; never multi-hot.
REQ-015 Priority per cycle SHALL be: rst > en low > load > scan advance.
REQ-016 en low SHALL move to IDLE next cycle: y=0, vld=0, wrap=0, index and dwell counter cleared; load ignored.
REQ-017 load with en high and mode=0 SHALL, from any state, next cycle enter HOLD with y[sel]=1, vld=1.
REQ-018 HOLD SHALL keep y constant until the next load, en low or rst.
REQ-019 load with en high and mode=1 SHALL, from any state, next cycle enter SCAN with index=sel, y[sel]=1, vld=1, dwell captured into internal register, counter=dwell.
REQ-020 Latency from load to updated y SHALL be exactly one cycle.
REQ-021 In SCAN, counter SHALL decrement each cycle while nonzero; when zero, index SHALL increment modulo 2**N and counter reload from captured dwell in the same cycle.
REQ-022 dwell=0 SHALL advance index every cycle; dwell=2**DW-1 SHALL hold each index 2**DW cycles.
REQ-023 wrap SHALL be registered, high exactly in the cycle y first shows index 0 after index 2**N-1; low otherwise.
REQ-024 load during SCAN SHALL restart the scan from new sel/dwell with no wrap pulse, even if the coincident advance would have wrapped.
REQ-025 sel/dwell changes without load SHALL have no effect.
REQ-026 Counter and index arithmetic SHALL be unsigned, fixed width DW and N, natural modulo wrap.

Reset
REQ-027 rst high at a clock edge SHALL set state IDLE, y=0, vld=0, wrap=0, index=0, counter=0, captured dwell=0.
REQ-028 rst asserted mid-HOLD or mid-SCAN SHALL abort immediately at that edge; load in the same cycle ignored.
REQ-029 After rst deasserts, block SHALL remain IDLE until a load with en high.

Verification (N=2, DW=4)
REQ-030 Direct: en=1, load, mode=0, sel=2 -> next cycle y=0100, vld=1; held 10 cycles unchanged.
REQ-031 Scan: load, mode=1, sel=1, dwell=2 -> y=0010 x3 cycles, 0100 x3, 1000 x3, then 0001 with wrap=1 for that first cycle only.
REQ-032 Fast scan: sel=3, dwell=0 -> y 1000,0001,0010,0100,1000...; wrap high every 4th cycle, on each 0001.
REQ-033 Reload: in SCAN at index 3 on final dwell cycle, load mode=0 sel=1 -> next y=0010, state HOLD, wrap=0.
REQ-034 Disable: en low mid-SCAN together with load -> next cycle y=0000, vld=0; en high without load -> stays IDLE.
REQ-035 Reset: rst high mid-SCAN -> next cycle all outputs zero; every cycle of all scenarios checks y is zero or one-hot.

Source files
------------

// File: rtl/dec_scan.sv
// One-hot decoder with direct-hold and timed scan modes.
// y, vld and wrap are registered; every command takes effect one cycle after load.
module dec_scan #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  input  logic [DW-1:0]     dwell,
  output logic [2**N-1:0]   y,
  output logic              vld,
  output logic              wrap
);

  localparam int unsigned NY = 2**N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_idx;
  logic [N-1:0]    w_idx_nxt;
  logic [N-1:0]    w_idx_adv;
  logic [DW-1:0]   r_cnt;
  logic [DW-1:0]   w_cnt_nxt;
  logic [DW-1:0]   r_dwell;
  logic [DW-1:0]   w_dwell_nxt;
  logic [NY-1:0]   w_y_nxt;
  logic            w_vld_nxt;
  logic            w_wrap_nxt;

  assign w_idx_adv = r_idx + N'(1);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dwell <= '0;
      y       <= '0;
      vld     <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dwell <= w_dwell_nxt;
      y       <= w_y_nxt;
      vld     <= w_vld_nxt;
      wrap    <= w_wrap_nxt;
    end
  end

  // Next state: disable beats load, load beats the scan advance
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_dwell_nxt = r_dwell;
    w_y_nxt     = y;
    w_vld_nxt   = vld;
    w_wrap_nxt  = 1'b0;

    if (!en) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_y_nxt     = '0;
      w_vld_nxt   = 1'b0;
    end else if (load) begin
      w_idx_nxt = sel;
      w_y_nxt   = NY'(1) << sel;
      w_vld_nxt = 1'b1;
      if (mode) begin
        w_state_nxt = SCAN;
        w_cnt_nxt   = dwell;
        w_dwell_nxt = dwell;
      end else begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = '0;
      end
    end else if (r_state == SCAN) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - DW'(1);
      end else begin
        // Dwell expired: step to the next index and re-arm the counter
        w_idx_nxt  = w_idx_adv;
        w_cnt_nxt  = r_dwell;
        w_y_nxt    = NY'(1) << w_idx_adv;
        w_wrap_nxt = (r_idx == {N{1'b1}});
      end
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// Directed and random stimulus for dec_scan, checked every cycle against
// a model that derives the scan position from elapsed time since the load.
module tb_dec_scan;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 4;
  localparam int unsigned NY = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            load;
  logic            mode;
  logic [N-1:0]    sel;
  logic [DW-1:0]   dwell;
  logic [NY-1:0]   y;
  logic            vld;
  logic            wrap;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 0 idle, 1 hold, 2 scan; m_t counts cycles since the scan began
  int m_st  = 0;
  int m_sel = 0;
  int m_dw  = 0;
  int m_t   = 0;

  dec_scan #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .mode  (mode),
    .sel   (sel),
    .dwell (dwell),
    .y     (y),
    .vld   (vld),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs present at the edge, clock, then compare
  task automatic step();
    int per, idx;
    logic [NY-1:0] ey;
    logic ev, ew;
    if (rst || !en) begin
      m_st = 0;
    end else if (load) begin
      m_st  = mode ? 2 : 1;
      m_sel = int'(sel);
      m_dw  = int'(dwell);
      m_t   = 0;
    end else if (m_st == 2) begin
      m_t++;
    end
    @(posedge clk);
    #1;
    ey = '0; ev = 1'b0; ew = 1'b0;
    if (m_st == 1) begin
      ey = NY'(1) << m_sel;
      ev = 1'b1;
    end else if (m_st == 2) begin
      per = m_dw + 1;
      idx = (m_sel + m_t / per) % NY;
      ey  = NY'(1) << idx;
      ev  = 1'b1;
      ew  = (m_t > 0) && (m_t % per == 0) && (idx == 0);
    end
    chk("y", 32'(y), 32'(ey));
    chk("vld", 32'(vld), 32'(ev));
    chk("wrap", 32'(wrap), 32'(ew));
    chk("onehot0", 32'($onehot0(y)), 32'd1);
  endtask

  task automatic cmd(input logic m, input logic [N-1:0] s, input logic [DW-1:0] d);
    load = 1'b1; mode = m; sel = s; dwell = d;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; sel = '0; dwell = '0;
    step();
    step();
    chk("rst_y", 32'(y), 32'd0);

    // Stay idle after reset until a load arrives
    rst = 1'b0; en = 1'b1;
    repeat (3) step();
    chk("post_rst_idle", 32'(vld), 32'd0);

    // Direct decode, held while sel/dwell wander without load
    cmd(1'b0, 2'd2, 4'd0);
    chk("dir_y", 32'(y), 32'h4);
    for (int i = 0; i < 10; i++) begin
      sel = N'($urandom); dwell = DW'($urandom); mode = 1'($urandom);
      step();
    end
    chk("dir_held", 32'(y), 32'h4);

    // Scan with dwell=2 across a wrap
    cmd(1'b1, 2'd1, 4'd2);
    repeat (13) step();

    // Fast scan, wrap every fourth cycle
    cmd(1'b1, 2'd3, 4'd0);
    repeat (12) step();

    // Load on the final dwell cycle at index 3 suppresses the wrap
    cmd(1'b1, 2'd3, 4'd1);
    step();
    cmd(1'b0, 2'd1, 4'd0);
    chk("reload_y", 32'(y), 32'h2);
    chk("reload_wrap", 32'(wrap), 32'd0);
    repeat (2) step();

    // Disable mid-scan with a coincident load
    cmd(1'b1, 2'd0, 4'd3);
    repeat (5) step();
    en = 1'b0; load = 1'b1; mode = 1'b1; sel = 2'd2;
    step();
    load = 1'b0;
    chk("dis_y", 32'(y), 32'd0);
    en = 1'b1;
    repeat (3) step();
    chk("dis_stay_idle", 32'(vld), 32'd0);

    // Reset mid-scan with a coincident load
    cmd(1'b1, 2'd2, 4'd1);
    repeat (3) step();
    rst = 1'b1; load = 1'b1; mode = 1'b0;
    step();
    rst = 1'b0; load = 1'b0;
    chk("rst_mid_vld", 32'(vld), 32'd0);
    repeat (2) step();

    // Maximum dwell: each index held 16 cycles
    cmd(1'b1, 2'd0, 4'd15);
    repeat (70) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 29) != 0);
      load  = ($urandom_range(0, 9) == 0);
      mode  = 1'($urandom);
      sel   = N'($urandom);
      dwell = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 2));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
